// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AXI3 read/write channel bundle for the SRAM slave
interface axi_sram_slave_if;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [1:0]  axi_arlock;
  logic [3:0]  axi_arcache;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;

  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [1:0]  axi_awlock;
  logic [3:0]  axi_awcache;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;

  logic [3:0]  axi_wid;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;

  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;

  modport slave (
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready,
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awlock, axi_awcache, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready
  );

  modport master (
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready,
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awlock, axi_awcache, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave over a 2^MEM_AW x 32-bit SRAM, INCR word bursts
// Independent read and write FSMs; read data is a combinational array lookup.
module axi_sram_slave #(
  parameter int MEM_AW = 10
) (
  input  logic            clk,
  input  logic            resetn,
  axi_sram_slave_if.slave axi
);
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef logic [MEM_AW-1:0] word_addr_t;

  localparam word_addr_t ADDR_ONE = word_addr_t'(1);

  logic [31:0] mem [2**MEM_AW];

  r_state_t   r_state, r_state_nxt;
  word_addr_t r_addr, r_addr_nxt;
  logic [7:0] r_cnt, r_cnt_nxt;
  logic [7:0] r_len, r_len_nxt;
  logic [3:0] r_id, r_id_nxt;

  w_state_t   w_state, w_state_nxt;
  word_addr_t w_addr, w_addr_nxt;
  logic [3:0] w_id, w_id_nxt;
  logic       w_hs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= r_state_nxt;
      r_addr  <= r_addr_nxt;
      r_cnt   <= r_cnt_nxt;
      r_len   <= r_len_nxt;
      r_id    <= r_id_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    r_addr_nxt  = r_addr;
    r_cnt_nxt   = r_cnt;
    r_len_nxt   = r_len;
    r_id_nxt    = r_id;
    case (r_state)
      R_IDLE: begin
        if (axi.axi_arvalid) begin
          r_state_nxt = R_DATA;
          r_addr_nxt  = axi.axi_araddr[MEM_AW+1:2];
          r_cnt_nxt   = '0;
          r_len_nxt   = axi.axi_arlen;
          r_id_nxt    = axi.axi_arid;
        end
      end
      R_DATA: begin
        if (axi.axi_rready) begin
          if (r_cnt == r_len) begin
            r_state_nxt = R_IDLE;
          end else begin
            r_cnt_nxt  = r_cnt + 8'd1;
            r_addr_nxt = r_addr + ADDR_ONE;
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign axi.axi_arready = (r_state == R_IDLE);
  assign axi.axi_rvalid  = (r_state == R_DATA);
  assign axi.axi_rdata   = mem[r_addr];
  assign axi.axi_rid     = r_id;
  assign axi.axi_rresp   = 2'b00;
  assign axi.axi_rlast   = (r_state == R_DATA) && (r_cnt == r_len);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_id    <= '0;
    end else begin
      w_state <= w_state_nxt;
      w_addr  <= w_addr_nxt;
      w_id    <= w_id_nxt;
    end
  end

  // The burst length comes from wlast alone; awlen is never consulted.
  always_comb begin
    w_state_nxt = w_state;
    w_addr_nxt  = w_addr;
    w_id_nxt    = w_id;
    case (w_state)
      W_IDLE: begin
        if (axi.axi_awvalid) begin
          w_state_nxt = W_DATA;
          w_addr_nxt  = axi.axi_awaddr[MEM_AW+1:2];
          w_id_nxt    = axi.axi_awid;
        end
      end
      W_DATA: begin
        if (axi.axi_wvalid) begin
          w_addr_nxt = w_addr + ADDR_ONE;
          if (axi.axi_wlast) w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (axi.axi_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign w_hs            = (w_state == W_DATA) && axi.axi_wvalid;
  assign axi.axi_awready = (w_state == W_IDLE);
  assign axi.axi_wready  = (w_state == W_DATA);
  assign axi.axi_bvalid  = (w_state == W_RESP);
  assign axi.axi_bid     = w_id;
  assign axi.axi_bresp   = 2'b00;

  // Array is not reset so its contents survive a resetn pulse.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.axi_wstrb[i]) mem[w_addr][8*i +: 8] <= axi.axi_wdata[8*i +: 8];
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{axi.axi_arsize, axi.axi_arburst, axi.axi_arlock,
                           axi.axi_arcache, axi.axi_arprot,
                           axi.axi_araddr[31:MEM_AW+2], axi.axi_araddr[1:0],
                           axi.axi_awsize, axi.axi_awburst, axi.axi_awlock,
                           axi.axi_awcache, axi.axi_awprot, axi.axi_awlen,
                           axi.axi_awaddr[31:MEM_AW+2], axi.axi_awaddr[1:0],
                           axi.axi_wid};
endmodule
